vga_sync_to_count: RTL and testbench

- Receiver end of the VGA sync-pulse interface.
- Takes the active-high visible-window HSync/VSync produced by the sync pulse generator and regenerates the column/row counts locally.
- Checks that the incoming syncs obey the programmed timing, and reports lock state and timing errors.
- Placed downstream of any sync-only link (for example, after a pipeline or clock-domain stage) so that consumers such as the pattern generator, pong logic or porch adder get counts aligned to their syncs.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_sync_to_count_edge_detect.sv | 37 +++
 rtl/vga_sync_to_count.sv | 160 ++++++++++++++++
 tb/tb_vga_sync_to_count.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, count width and lock-state encoding for the
// sync-to-count receiver.
package vga_timing_pkg;

  localparam int c_DEF_VISIBLE_COLUMNS = 640;
  localparam int c_DEF_VISIBLE_ROWS    = 480;
  localparam int c_DEF_TOTAL_COLUMNS   = 800;
  localparam int c_DEF_TOTAL_ROWS      = 525;
  localparam int c_COUNT_W             = 10;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  function automatic logic [c_COUNT_W-1:0] wrap_inc(input logic [c_COUNT_W-1:0] v,
                                                    input logic [c_COUNT_W-1:0] last);
    return (v == last) ? '0 : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_to_count_edge_detect.sv
// Registers the incoming syncs (these registers are also the delayed sync
// outputs) and produces same-cycle rise strobes against the previous value.
module vga_sync_edge_detect (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_HSync,
  input  logic i_VSync,
  output logic o_HSync,
  output logic o_VSync,
  output logic o_HRise,
  output logic o_VRise
);

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;

  always_comb begin
    hsync_d = i_HSync;
    vsync_d = i_VSync;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign o_HSync = hsync_q;
  assign o_VSync = vsync_q;
  assign o_HRise = i_HSync & ~hsync_q;
  assign o_VRise = i_VSync & ~vsync_q;

endmodule

// File: rtl/vga_sync_to_count.sv
// Regenerates column/row counts from incoming visible-window syncs, checks
// the sync timing against the programmed geometry and tracks lock.
//
// state    | meaning
// UNLOCKED | counts held at 0, errors ignored, waiting for first VSync rise
// ACQUIRE  | counting and checking; need c_LOCK_FRAMES clean frame starts
// LOCKED   | counts trusted; any timing error falls back to ACQUIRE
module vga_sync_to_count
  import vga_timing_pkg::*;
#(
  parameter int c_VISIBLE_COLUMNS = c_DEF_VISIBLE_COLUMNS,
  parameter int c_VISIBLE_ROWS    = c_DEF_VISIBLE_ROWS,
  parameter int c_TOTAL_COLUMNS   = c_DEF_TOTAL_COLUMNS,
  parameter int c_TOTAL_ROWS      = c_DEF_TOTAL_ROWS,
  parameter int c_LOCK_FRAMES     = 2
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_HSync,
  input  logic                 i_VSync,
  output logic                 o_HSync,
  output logic                 o_VSync,
  output logic [c_COUNT_W-1:0] o_ColCount,
  output logic [c_COUNT_W-1:0] o_RowCount,
  output logic                 o_FrameStart,
  output logic                 o_Locked,
  output logic                 o_SyncError,
  output logic [7:0]           o_ErrorCount
);

  localparam logic [c_COUNT_W-1:0] c_COL_LAST = c_COUNT_W'(c_TOTAL_COLUMNS - 1);
  localparam logic [c_COUNT_W-1:0] c_ROW_LAST = c_COUNT_W'(c_TOTAL_ROWS - 1);
  localparam logic [3:0]           c_LOCK_N   = 4'(c_LOCK_FRAMES);

  // Visible windows must sit inside the line/frame and counts must fit 10 bits.
  generate
    if (c_VISIBLE_COLUMNS < 1 || c_VISIBLE_COLUMNS >= c_TOTAL_COLUMNS ||
        c_VISIBLE_ROWS < 1 || c_VISIBLE_ROWS >= c_TOTAL_ROWS ||
        c_TOTAL_COLUMNS > 1024 || c_TOTAL_ROWS > 1024 ||
        c_LOCK_FRAMES < 1 || c_LOCK_FRAMES > 15) begin : g_bad_params
      $error("vga_sync_to_count: illegal timing parameters");
    end
  endgenerate

  lock_state_e state_q, state_d;

  logic [c_COUNT_W-1:0] col_q, col_d;
  logic [c_COUNT_W-1:0] row_q, row_d;
  logic                 frame_start_q, frame_start_d;
  logic                 sync_err_q, sync_err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic [3:0]           good_q, good_d;

  logic h_rise, v_rise;
  logic at_eol, at_eof, err;

  vga_sync_edge_detect u_edge (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_HSync (i_HSync),
    .i_VSync (i_VSync),
    .o_HSync (o_HSync),
    .o_VSync (o_VSync),
    .o_HRise (h_rise),
    .o_VRise (v_rise)
  );

  // An HSync rise is expected exactly at end of line, a VSync rise exactly at
  // end of frame; any disagreement in a cycle is a single error.
  always_comb begin
    at_eol = (col_q == c_COL_LAST);
    at_eof = at_eol && (row_q == c_ROW_LAST);
    err    = (state_q != UNLOCKED) &&
             ((h_rise != at_eol) || (v_rise != at_eof));
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state_q <= UNLOCKED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      UNLOCKED: begin
        if (v_rise) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      ACQUIRE: begin
        if (err) begin
          good_d = '0;
        end else if (v_rise) begin
          good_d = good_q + 4'd1;
          if (good_d == c_LOCK_N) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (err) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = UNLOCKED;
        good_d  = '0;
      end
    endcase
  end

  always_comb begin
    o_Locked = (state_q == LOCKED);
  end

  // Rises realign the counters even when they flag an error.
  always_comb begin
    col_d = col_q + 10'd1;
    row_d = row_q;
    if (state_q == UNLOCKED) begin
      col_d = '0;
      row_d = '0;
    end else if (v_rise) begin
      col_d = '0;
      row_d = '0;
    end else if (h_rise || at_eol) begin
      col_d = '0;
      row_d = wrap_inc(row_q, c_ROW_LAST);
    end
    frame_start_d = v_rise;
    sync_err_d    = err;
    err_cnt_d     = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_cnt_q     <= '0;
      good_q        <= '0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      err_cnt_q     <= err_cnt_d;
      good_q        <= good_d;
    end
  end

  assign o_ColCount   = col_q;
  assign o_RowCount   = row_q;
  assign o_FrameStart = frame_start_q;
  assign o_SyncError  = sync_err_q;
  assign o_ErrorCount = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Bench for vga_sync_to_count on a reduced 12x8 geometry: a linear-position
// reference model checked every cycle plus directed scenario checks.
`timescale 1ns/1ps
module tb_vga_sync_to_count;

  localparam int VC = 8, VR = 6, TC = 12, TR = 8, LF = 2;
  localparam int FRAME = TC * TR;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_HSync, i_VSync;
  logic       o_HSync, o_VSync, o_FrameStart, o_Locked, o_SyncError;
  logic [9:0] o_ColCount, o_RowCount;
  logic [7:0] o_ErrorCount;

  vga_sync_to_count #(
    .c_VISIBLE_COLUMNS (VC),
    .c_VISIBLE_ROWS    (VR),
    .c_TOTAL_COLUMNS   (TC),
    .c_TOTAL_ROWS      (TR),
    .c_LOCK_FRAMES     (LF)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_HSync      (i_HSync),
    .i_VSync      (i_VSync),
    .o_HSync      (o_HSync),
    .o_VSync      (o_VSync),
    .o_ColCount   (o_ColCount),
    .o_RowCount   (o_RowCount),
    .o_FrameStart (o_FrameStart),
    .o_Locked     (o_Locked),
    .o_SyncError  (o_SyncError),
    .o_ErrorCount (o_ErrorCount)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the recovered position is one linear pixel index.
  int m_pos, m_state, m_good, m_err_cnt;
  bit m_fs, m_serr, m_hs, m_vs, m_ph, m_pv;

  always @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      m_pos = 0; m_state = 0; m_good = 0; m_err_cnt = 0;
      m_fs = 0; m_serr = 0; m_hs = 0; m_vs = 0; m_ph = 0; m_pv = 0;
    end else begin
      bit hr, vr, eol, eof, bad;
      int col, row;
      hr  = i_HSync && !m_ph;
      vr  = i_VSync && !m_pv;
      col = m_pos % TC;
      row = m_pos / TC;
      eol = (col == TC - 1);
      eof = eol && (row == TR - 1);
      bad = (m_state != 0) && ((hr != eol) || (vr != eof));
      if (m_state == 0 || vr) m_pos = 0;
      else if (hr)            m_pos = ((row + 1) % TR) * TC;
      else                    m_pos = (m_pos + 1) % FRAME;
      case (m_state)
        0: if (vr) begin m_state = 1; m_good = 0; end
        1: if (bad) m_good = 0;
           else if (vr) begin
             m_good++;
             if (m_good == LF) m_state = 2;
           end
        default: if (bad) begin m_state = 1; m_good = 0; end
      endcase
      if (bad && m_err_cnt < 255) m_err_cnt++;
      m_fs = vr; m_serr = bad; m_hs = i_HSync; m_vs = i_VSync;
      m_ph = i_HSync; m_pv = i_VSync;
    end
  end

  int fs_seen = 0, serr_seen = 0;

  always @(negedge i_Clk) begin
    chk("hsync", o_HSync, m_hs);
    chk("vsync", o_VSync, m_vs);
    chk("col", o_ColCount, m_pos % TC);
    chk("row", o_RowCount, m_pos / TC);
    chk("frame_start", o_FrameStart, m_fs);
    chk("locked", o_Locked, m_state == 2);
    chk("sync_error", o_SyncError, m_serr);
    chk("error_count", o_ErrorCount, m_err_cnt);
    if (o_FrameStart) chk("fs_origin", o_ColCount + o_RowCount, 0);
    if (o_FrameStart) fs_seen++;
    if (o_SyncError) serr_seen++;
  end

  // Stimulus generator.
  int gen_col, gen_row, kill_row;
  bit vs_kill, restart, sat_mode, sat_tog;

  task automatic drive();
    i_HSync = (gen_col < VC) && (gen_row != kill_row);
    i_VSync = (gen_row < VR) && !vs_kill;
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
    if (restart) begin
      gen_col = 0; gen_row = 0; restart = 0;
    end else begin
      gen_col++;
      if (gen_col == TC) begin
        gen_col = 0;
        gen_row = (gen_row + 1) % TR;
      end
    end
    if (sat_mode) begin
      sat_tog = !sat_tog;
      i_HSync = sat_tog;
      i_VSync = 1'b0;
    end else begin
      drive();
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int r, input int c);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!(gen_row == r && gen_col == c) && k < 2 * FRAME);
    if (!(gen_row == r && gen_col == c)) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_to: position (%0d,%0d) not reached in %0d cycles", r, c, k);
    end
  endtask

  initial begin
    int k, s0, f0;
    i_Reset = 1'b1;
    gen_row = 6; gen_col = 5; kill_row = -1;
    vs_kill = 0; restart = 0; sat_mode = 0; sat_tog = 0;
    drive();
    run(3);
    chk("rst_col", o_ColCount, 0);
    chk("rst_row", o_RowCount, 0);
    chk("rst_locked", o_Locked, 0);
    chk("rst_errcnt", o_ErrorCount, 0);
    i_Reset = 1'b0;

    // Acquisition: lock two frames after the first frame start.
    k = 0;
    while (!o_FrameStart && k < 2 * FRAME) begin step(); k++; end
    chk("first_fs", o_FrameStart, 1);
    chk("first_fs_col", o_ColCount, 0);
    chk("first_fs_locked", o_Locked, 0);
    k = 0;
    while (!o_Locked && k < 3 * FRAME) begin step(); k++; end
    chk("lock_latency", k, 2 * FRAME);
    run(3 * FRAME);
    chk("clean_errcnt", o_ErrorCount, 0);
    chk("clean_locked", o_Locked, 1);

    // Missing HSync for one line.
    run_to(0, 0);
    kill_row = 3;
    s0 = serr_seen;
    run_to(4, 2);
    kill_row = -1;
    chk("glitch_pulses", serr_seen - s0, 1);
    chk("glitch_errcnt", o_ErrorCount, 1);
    chk("glitch_unlocked", o_Locked, 0);
    run(3 * FRAME);
    chk("glitch_relock", o_Locked, 1);

    // Generator restarted from vertical blanking.
    run_to(6, 10);
    restart = 1;
    step();
    step();
    chk("early_col", o_ColCount, 0);
    chk("early_row", o_RowCount, 0);
    chk("early_errcnt", o_ErrorCount, 2);
    chk("early_locked", o_Locked, 0);
    run(3 * FRAME);

    // One frame with VSync suppressed.
    run_to(7, 0);
    vs_kill = 1;
    f0 = fs_seen;
    run(FRAME);
    vs_kill = 0;
    chk("missing_fs", fs_seen - f0, 0);
    chk("missing_errcnt", o_ErrorCount, 3);
    run(FRAME);

    // HSync toggling every cycle: an E1 error every second cycle.
    sat_mode = 1;
    run(600);
    chk("sat_errcnt", o_ErrorCount, 255);

    // Asynchronous reset between clock edges.
    step();
    #1;
    i_Reset = 1'b1;
    #1;
    chk("arst_hsync", o_HSync, 0);
    chk("arst_vsync", o_VSync, 0);
    chk("arst_col", o_ColCount, 0);
    chk("arst_row", o_RowCount, 0);
    chk("arst_fs", o_FrameStart, 0);
    chk("arst_locked", o_Locked, 0);
    chk("arst_serr", o_SyncError, 0);
    chk("arst_errcnt", o_ErrorCount, 0);
    sat_mode = 0;
    gen_row = 6; gen_col = 4;
    drive();
    run(3);
    i_Reset = 1'b0;
    run(4 * FRAME);
    chk("post_rst_errcnt", o_ErrorCount, 0);
    chk("post_rst_locked", o_Locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
